// File: rtl/vending_machine_core.sv
// rtl/vending_machine_core.sv - N-slot vending controller with per-slot price/stock and coin-by-coin change
// Define VM_RESTOCK_EN to add the restock/restockIdx inputs that refill one slot to full.
module vending_machine_core #(
    parameter int NUM_SLOTS       = 9,
    parameter int CREDIT_W        = 12,
    parameter int MAX_CREDIT      = 1000,
    parameter int STOCK_W         = 4,
    parameter int INIT_STOCK      = 5,
    parameter int DISPENSE_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          coinValid,
    input  logic [2:0]                    coinType,
    input  logic                          selValid,
    input  logic [3:0]                    selIdx,
    input  logic                          cancel,
    input  logic [NUM_SLOTS*CREDIT_W-1:0] priceFlat,
    input  logic                          changeReady,
`ifdef VM_RESTOCK_EN
    input  logic                          restock,
    input  logic [3:0]                    restockIdx,
`endif
    output logic [CREDIT_W-1:0]           credit,
    output logic                          dispense,
    output logic [3:0]                    dispIdx,
    output logic                          changeValid,
    output logic [2:0]                    changeCoin,
    output logic                          coinReject,
    output logic                          denyPulse,
    output logic [NUM_SLOTS-1:0]          gLED,
    output logic [NUM_SLOTS-1:0]          rLED
);
    localparam int CNT_W = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_DISPENSE, S_CHANGE} state_t;

    state_t               r_state;
    logic [CREDIT_W-1:0]  r_credit;
    logic [STOCK_W-1:0]   r_stock [NUM_SLOTS];
    logic [CNT_W-1:0]     r_disp_cnt;
    logic                 r_dispense;
    logic [3:0]           r_disp_idx;
    logic                 r_change_valid;
    logic [2:0]           r_change_coin;
    logic                 r_coin_reject;
    logic                 r_deny;

    logic [CREDIT_W-1:0]  w_price [NUM_SLOTS];
    logic [CREDIT_W-1:0]  w_sel_price;
    logic [STOCK_W-1:0]   w_sel_stock;
    logic [31:0]          w_coin_sum;
    logic                 w_coin_ok;
    logic                 w_sel_ok;
    logic                 w_restock_block;
    logic                 w_go_change;
    logic [CREDIT_W-1:0]  w_change_rem;
    logic [CREDIT_W-1:0]  w_chg_val;

    function automatic logic [31:0] coin_value(input logic [2:0] code);
        case (code)
            3'd0:    return 32'd5;
            3'd1:    return 32'd10;
            3'd2:    return 32'd25;
            3'd3:    return 32'd50;
            3'd4:    return 32'd100;
            3'd5:    return 32'd500;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [2:0] largest_coin(input logic [31:0] v);
        if (v >= 32'd500)      return 3'd5;
        else if (v >= 32'd100) return 3'd4;
        else if (v >= 32'd50)  return 3'd3;
        else if (v >= 32'd25)  return 3'd2;
        else if (v >= 32'd10)  return 3'd1;
        else                   return 3'd0;
    endfunction

    always_comb begin
        w_sel_price = '0;
        w_sel_stock = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_price[i] = priceFlat[i*CREDIT_W +: CREDIT_W];
            gLED[i]    = (r_stock[i] != '0) && (w_price[i] != '0) && (r_credit >= w_price[i]);
            rLED[i]    = (r_stock[i] == '0) || (w_price[i] == '0);
            if (selIdx == 4'(i)) begin
                w_sel_price = w_price[i];
                w_sel_stock = r_stock[i];
            end
        end
    end

`ifdef VM_RESTOCK_EN
    assign w_restock_block = restock && (restockIdx == selIdx);
`else
    assign w_restock_block = 1'b0;
`endif

    // Out-of-range selections see price 0 from the lookup and are refused like disabled slots.
    assign w_coin_sum   = 32'(r_credit) + coin_value(coinType);
    assign w_coin_ok    = (coinType <= 3'd5) && (w_coin_sum <= 32'(MAX_CREDIT));
    assign w_sel_ok     = (w_sel_price != '0) && (w_sel_stock != '0) &&
                          (r_credit >= w_sel_price) && !w_restock_block;
    assign w_change_rem = r_credit - CREDIT_W'(coin_value(r_change_coin));
    assign w_chg_val    = (r_state == S_CHANGE) ? w_change_rem : r_credit;

    always_comb begin
        w_go_change = 1'b0;
        case (r_state)
            S_IDLE:     w_go_change = cancel && (r_credit != '0);
            S_DISPENSE: w_go_change = (r_disp_cnt == '0);
            S_CHANGE:   w_go_change = changeReady;
            default:    w_go_change = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_credit       <= '0;
            r_disp_cnt     <= '0;
            r_dispense     <= 1'b0;
            r_disp_idx     <= '0;
            r_change_valid <= 1'b0;
            r_change_coin  <= '0;
            r_coin_reject  <= 1'b0;
            r_deny         <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) r_stock[i] <= STOCK_W'(INIT_STOCK);
        end else begin
            r_coin_reject <= 1'b0;
            r_deny        <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!cancel) begin
                        if (coinValid) begin
                            if (w_coin_ok) r_credit <= CREDIT_W'(w_coin_sum);
                            else           r_coin_reject <= 1'b1;
                        end else if (selValid) begin
                            if (w_sel_ok) begin
                                r_credit   <= r_credit - w_sel_price;
                                r_disp_idx <= selIdx;
                                r_dispense <= 1'b1;
                                r_disp_cnt <= CNT_W'(DISPENSE_CYCLES - 1);
                                r_state    <= S_DISPENSE;
                                for (int i = 0; i < NUM_SLOTS; i++)
                                    if (selIdx == 4'(i)) r_stock[i] <= r_stock[i] - STOCK_W'(1);
                            end else begin
                                r_deny <= 1'b1;
                            end
                        end
                    end
`ifdef VM_RESTOCK_EN
                    for (int i = 0; i < NUM_SLOTS; i++)
                        if (restock && (restockIdx == 4'(i))) r_stock[i] <= '1;
`endif
                end
                S_DISPENSE: begin
                    r_coin_reject <= coinValid;
                    if (r_disp_cnt == '0) r_dispense <= 1'b0;
                    else                  r_disp_cnt <= r_disp_cnt - CNT_W'(1);
                end
                S_CHANGE: r_coin_reject <= coinValid;
                default:  r_state <= S_IDLE;
            endcase
            // A residue below 5c cannot be paid out and is dropped when change ends.
            if (w_go_change) begin
                if (32'(w_chg_val) >= 32'd5) begin
                    r_state        <= S_CHANGE;
                    r_change_valid <= 1'b1;
                    r_change_coin  <= largest_coin(32'(w_chg_val));
                    r_credit       <= w_chg_val;
                end else begin
                    r_state        <= S_IDLE;
                    r_change_valid <= 1'b0;
                    r_credit       <= '0;
                end
            end
        end
    end

    assign credit      = r_credit;
    assign dispense    = r_dispense;
    assign dispIdx     = r_disp_idx;
    assign changeValid = r_change_valid;
    assign changeCoin  = r_change_coin;
    assign coinReject  = r_coin_reject;
    assign denyPulse   = r_deny;
endmodule

// File: tb/tb_vending_machine_core.sv
// tb/tb_vending_machine_core.sv - directed plus randomized checks of vending_machine_core against a transaction-level model
module tb_vending_machine_core;
    localparam int NS = 9, CW = 12, MAXC = 1000, SW = 4, INIT = 5, DC = 2;
`ifdef VM_RESTOCK_EN
    localparam bit RESTOCK = 1'b1;
`else
    localparam bit RESTOCK = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n, coinValid, selValid, cancel, changeReady;
    logic [2:0]      coinType;
    logic [3:0]      selIdx;
    logic [NS*CW-1:0] priceFlat;
`ifdef VM_RESTOCK_EN
    logic            restock;
    logic [3:0]      restockIdx;
`endif
    logic [CW-1:0]   credit;
    logic            dispense, changeValid, coinReject, denyPulse;
    logic [3:0]      dispIdx;
    logic [2:0]      changeCoin;
    logic [NS-1:0]   gLED, rLED;

    vending_machine_core #(
        .NUM_SLOTS(NS), .CREDIT_W(CW), .MAX_CREDIT(MAXC), .STOCK_W(SW),
        .INIT_STOCK(INIT), .DISPENSE_CYCLES(DC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .coinValid(coinValid), .coinType(coinType),
        .selValid(selValid), .selIdx(selIdx), .cancel(cancel), .priceFlat(priceFlat),
        .changeReady(changeReady),
`ifdef VM_RESTOCK_EN
        .restock(restock), .restockIdx(restockIdx),
`endif
        .credit(credit), .dispense(dispense), .dispIdx(dispIdx), .changeValid(changeValid),
        .changeCoin(changeCoin), .coinReject(coinReject), .denyPulse(denyPulse),
        .gLED(gLED), .rLED(rLED)
    );

    int n_checks = 0, n_pass = 0, n_fail = 0;
    int m_credit;
    int m_stock [NS];
    int m_price [NS];
    int coin_val [8] = '{5, 10, 25, 50, 100, 500, 0, 0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_prices();
        for (int i = 0; i < NS; i++) priceFlat[i*CW +: CW] = CW'(m_price[i]);
    endtask

    function automatic int best_coin(input int v);
        for (int k = 5; k >= 0; k--) if (coin_val[k] <= v) return k;
        return -1;
    endfunction

    task automatic check_leds();
        logic [NS-1:0] eg, er;
        for (int i = 0; i < NS; i++) begin
            eg[i] = (m_stock[i] > 0) && (m_price[i] != 0) && (m_credit >= m_price[i]);
            er[i] = (m_stock[i] == 0) || (m_price[i] == 0);
        end
        check("gLED", 32'(gLED), 32'(eg));
        check("rLED", 32'(rLED), 32'(er));
    endtask

    task automatic run_change(input int stall);
        int  cyc, k;
        bit  rdy, cv;
        cyc = 0;
        while (m_credit >= 5 && cyc < 400) begin
            k = best_coin(m_credit);
            check("changeValid", 32'(changeValid), 32'd1);
            check("changeCoin", 32'(changeCoin), 32'(k));
            rdy = (stall >= 0) ? (cyc >= stall) : 1'($urandom_range(0, 1));
            cv  = ($urandom_range(0, 3) == 0);
            changeReady = rdy;
            coinValid   = cv;
            coinType    = 3'($urandom_range(0, 5));
            selValid    = 1'($urandom_range(0, 1));
            selIdx      = 4'd0;
            cancel      = 1'($urandom_range(0, 1));
            step();
            changeReady = 0; coinValid = 0; selValid = 0; cancel = 0;
            check("coinReject_busy", 32'(coinReject), 32'(cv));
            check("denyPulse_busy", 32'(denyPulse), 32'd0);
            if (rdy) begin
                m_credit -= coin_val[k];
                if (m_credit < 5) m_credit = 0;
            end
            check("credit_change", 32'(credit), 32'(m_credit));
            cyc++;
        end
        check("change_bound", 32'(cyc < 400), 32'd1);
        check("changeValid_end", 32'(changeValid), 32'd0);
    endtask

    task automatic dispense_phase(input int idx);
        bit cv;
        check("dispense_start", 32'(dispense), 32'd1);
        check("dispIdx", 32'(dispIdx), 32'(idx));
        for (int c = 1; c < DC; c++) begin
            cv = 1'($urandom_range(0, 1));
            coinValid = cv; coinType = 3'd0;
            step();
            coinValid = 0;
            check("coinReject_disp", 32'(coinReject), 32'(cv));
            check("dispense_hold", 32'(dispense), 32'd1);
        end
        step();
        check("dispense_end", 32'(dispense), 32'd0);
        if (m_credit >= 5) run_change(-1);
        else begin
            m_credit = 0;
            check("changeValid_nochg", 32'(changeValid), 32'd0);
        end
        check("credit_after_disp", 32'(credit), 32'(m_credit));
    endtask

    task automatic idle_event(input bit c, input bit cv, input int ct, input bit sv,
                              input int si, input bit rs, input int ridx, input int stall);
        bit exp_rej, exp_deny, do_disp, do_chg;
        exp_rej = 0; exp_deny = 0; do_disp = 0; do_chg = 0;
        cancel = c; coinValid = cv; coinType = 3'(ct); selValid = sv; selIdx = 4'(si);
`ifdef VM_RESTOCK_EN
        restock = rs; restockIdx = 4'(ridx);
`endif
        step();
        cancel = 0; coinValid = 0; selValid = 0;
`ifdef VM_RESTOCK_EN
        restock = 0;
`endif
        if (c) begin
            if (m_credit >= 5) do_chg = 1;
            else m_credit = 0;
        end else if (cv) begin
            if (ct >= 6 || m_credit + coin_val[ct] > MAXC) exp_rej = 1;
            else m_credit += coin_val[ct];
        end else if (sv) begin
            if (si >= NS) exp_deny = 1;
            else if ((RESTOCK && rs && ridx == si) || m_price[si] == 0 ||
                     m_stock[si] == 0 || m_credit < m_price[si]) exp_deny = 1;
            else begin
                m_credit -= m_price[si];
                m_stock[si]--;
                do_disp = 1;
            end
        end
        if (RESTOCK && rs && ridx < NS) m_stock[ridx] = 2**SW - 1;
        check("coinReject", 32'(coinReject), 32'(exp_rej));
        check("denyPulse", 32'(denyPulse), 32'(exp_deny));
        check("credit", 32'(credit), 32'(m_credit));
        check("dispense", 32'(dispense), 32'(do_disp));
        if (do_disp) dispense_phase(si);
        else if (do_chg) run_change(stall);
        else check("changeValid_idle", 32'(changeValid), 32'd0);
        check_leds();
    endtask

    task automatic ins(input int ct);
        idle_event(0, 1, ct, 0, 0, 0, 0, -1);
    endtask

    task automatic sel(input int si);
        idle_event(0, 0, 0, 1, si, 0, 0, -1);
    endtask

    task automatic cnl(input int stall);
        idle_event(1, 0, 0, 0, 0, 0, 0, stall);
    endtask

    task automatic model_reset();
        m_credit = 0;
        for (int i = 0; i < NS; i++) m_stock[i] = INIT;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        rst_n = 0; coinValid = 0; coinType = 0; selValid = 0; selIdx = 0;
        cancel = 0; changeReady = 0;
`ifdef VM_RESTOCK_EN
        restock = 0; restockIdx = 0;
`endif
        for (int i = 0; i < NS; i++) m_price[i] = 150;
        push_prices();
        model_reset();
        step(); step();
        check("rst_credit", 32'(credit), 32'd0);
        check("rst_dispense", 32'(dispense), 32'd0);
        check("rst_dispIdx", 32'(dispIdx), 32'd0);
        check("rst_changeValid", 32'(changeValid), 32'd0);
        check("rst_changeCoin", 32'(changeCoin), 32'd0);
        check("rst_coinReject", 32'(coinReject), 32'd0);
        check("rst_denyPulse", 32'(denyPulse), 32'd0);
        rst_n = 1;
        step();
        check_leds();

        ins(4); ins(3);
        check("gLED_all_on", 32'(gLED), 32'h1ff);
        cnl(-1);

        m_price[0] = 125; push_prices();
        ins(4); sel(0);
        ins(2); sel(0);

        ins(5); ins(4); ins(4); ins(4); ins(4);
        check("credit_900", 32'(credit), 32'd900);
        ins(5); ins(7);
        cnl(-1);

        ins(4); ins(3); ins(2); ins(1); ins(0);
        check("credit_190", 32'(credit), 32'd190);
        cnl(3);

        for (int n = 0; n < 6; n++) begin
            ins(4); ins(3); sel(2);
        end
        check("rLED2_soldout", 32'(rLED[2]), 32'd1);
        idle_event(0, 0, 0, 0, 0, 1, 2, -1);
`ifdef VM_RESTOCK_EN
        check("rLED2_restocked", 32'(rLED[2]), 32'd0);
`endif
        cnl(-1);

        for (int it = 0; it < 200; it++) begin
            if (it % 25 == 0) begin
                for (int i = 0; i < NS; i++) begin
                    r = $urandom_range(0, 7);
                    if (r == 0)      m_price[i] = 0;
                    else if (r == 1) m_price[i] = $urandom_range(1, 400);
                    else             m_price[i] = 5 * $urandom_range(1, 60);
                end
                push_prices();
                step();
                check_leds();
            end
            r = $urandom_range(0, 9);
            if (r <= 3)      ins((r == 0) ? $urandom_range(0, 7) : $urandom_range(0, 4));
            else if (r <= 6) sel($urandom_range(0, NS + 1));
            else if (r == 7) cnl(-1);
            else if (r == 8) idle_event(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                        $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                                        $urandom_range(0, NS - 1), 1'($urandom_range(0, 1)),
                                        $urandom_range(0, NS - 1), -1);
            else begin
                r = $urandom_range(0, NS - 1);
                idle_event(0, 0, 0, 1, r, 1, r, -1);
            end
        end

        cnl(-1);
        ins(3); ins(2);
        cancel = 1; changeReady = 0;
        step();
        cancel = 0;
        check("chg75_valid", 32'(changeValid), 32'd1);
        check("chg75_coin", 32'(changeCoin), 32'd3);
        #2 rst_n = 0;
        #1;
        model_reset();
        check("arst_credit", 32'(credit), 32'd0);
        check("arst_changeValid", 32'(changeValid), 32'd0);
        check("arst_changeCoin", 32'(changeCoin), 32'd0);
        check("arst_dispense", 32'(dispense), 32'd0);
        check("arst_dispIdx", 32'(dispIdx), 32'd0);
        check("arst_coinReject", 32'(coinReject), 32'd0);
        check("arst_denyPulse", 32'(denyPulse), 32'd0);
        check_leds();
        step();
        rst_n = 1;
        step();
        ins(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
